score_counter: RTL and testbench

- Consumer of the button processor's count_up / count_down pulses.
- Holds one team's score as two BCD digits (00..MAX_SCORE) for the 7-segment display path.
- Converts multi-cycle input pulses into single count events and applies a post-event lockout.
- Saturates at both ends and drives a timed "changed" flag for display blinking.

---
 rtl/score_counter_if.sv | 34 +++
 rtl/score_counter.sv | 149 ++++++++++++++
 tb/tb_score_counter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_counter_if.sv
// rtl/score_counter_if.sv - signal bundle between the button processor and the score counter
//
// Purpose: carries the count requests and clear into the score counter and the
// BCD digits plus status flags back out to the display path.
// Signals:
//   count_up_i    increment request pulse (any width >= 1 cycle)
//   count_down_i  decrement request pulse (any width >= 1 cycle)
//   clear_i       synchronous level-sensitive score clear
//   tens_o        BCD tens digit
//   ones_o        BCD ones digit
//   changed_o     high for FLASH_TIME cycles after an accepted change
//   at_max_o      score == MAX_SCORE
//   at_min_o      score == 0
// Modports: master drives the requests, slave (the counter) drives the results.
interface score_counter_if;
  logic       count_up_i;
  logic       count_down_i;
  logic       clear_i;
  logic [3:0] tens_o;
  logic [3:0] ones_o;
  logic       changed_o;
  logic       at_max_o;
  logic       at_min_o;

  modport master (
    output count_up_i, count_down_i, clear_i,
    input  tens_o, ones_o, changed_o, at_max_o, at_min_o
  );

  modport slave (
    input  count_up_i, count_down_i, clear_i,
    output tens_o, ones_o, changed_o, at_max_o, at_min_o
  );
endinterface

// File: rtl/score_counter.sv
// rtl/score_counter.sv - two-digit BCD team score with edge detect, lockout and change flash
//
// Purpose: turns count_up/count_down pulses into single +1/-1 score events,
// blocks further events for LOCKOUT_TIME cycles after each accepted one,
// saturates at 0 and MAX_SCORE, and flags every accepted change for
// FLASH_TIME cycles so the display can blink.
// Ports:
//   clk_1khz  1 kHz system clock
//   rst_n_i   asynchronous active-low reset
//   bus       score_counter_if.slave (requests in, digits and flags out)
module score_counter #(
  parameter int MAX_SCORE    = 99,
  parameter int LOCKOUT_TIME = 5,
  parameter int FLASH_TIME   = 250
) (
  input  logic            clk_1khz,
  input  logic            rst_n_i,
  score_counter_if.slave  bus
);

  localparam int              LOCK_W     = $clog2(LOCKOUT_TIME + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_TIME - 1);
  localparam logic [9:0]      FLASH_LOAD = 10'(FLASH_TIME);
  localparam logic [6:0]      MAX_BIN    = 7'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_READY  = 2'b00,
    ST_LOCKED = 2'b01
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_up_prev;
  logic              r_down_prev;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [LOCK_W-1:0] w_lock_next;
  logic [LOCK_W-1:0] w_lock_inc;
  logic [9:0]        r_flash_cnt;
  logic [9:0]        w_flash_next;
  logic [3:0]        r_tens;
  logic [3:0]        r_ones;
  logic [3:0]        w_tens_next;
  logic [3:0]        w_ones_next;
  logic              r_at_max;
  logic              r_at_min;
  logic              w_up_evt;
  logic              w_down_evt;
  logic [6:0]        w_score;
  logic [6:0]        w_score_next;

  assign w_up_evt   = bus.count_up_i & ~r_up_prev;
  assign w_down_evt = bus.count_down_i & ~r_down_prev;
  assign w_score    = 7'(r_tens) * 7'd10 + 7'(r_ones);
  assign w_lock_inc = r_lock_cnt + LOCK_W'(1);

  always_ff @(posedge clk_1khz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_READY;
      // History starts high so an input already asserted at reset release is not an edge.
      r_up_prev   <= 1'b1;
      r_down_prev <= 1'b1;
      r_lock_cnt  <= '0;
      r_flash_cnt <= '0;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_at_max    <= 1'b0;
      r_at_min    <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_up_prev   <= bus.count_up_i;
      r_down_prev <= bus.count_down_i;
      r_lock_cnt  <= w_lock_next;
      r_flash_cnt <= w_flash_next;
      r_tens      <= w_tens_next;
      r_ones      <= w_ones_next;
      r_at_max    <= (w_score_next == MAX_BIN);
      r_at_min    <= (w_score_next == 7'd0);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lock_next  = r_lock_cnt;
    w_tens_next  = r_tens;
    w_ones_next  = r_ones;
    w_flash_next = (r_flash_cnt != 10'd0) ? r_flash_cnt - 10'd1 : 10'd0;

    if (bus.clear_i) begin
      // Clear outranks everything; only an actual change of score blinks.
      w_state_next = ST_READY;
      w_lock_next  = '0;
      w_tens_next  = 4'd0;
      w_ones_next  = 4'd0;
      if (w_score != 7'd0) begin
        w_flash_next = FLASH_LOAD;
      end
    end else begin
      case (r_state)
        ST_READY: begin
          // Simultaneous up and down edges cancel out and are dropped.
          if (w_up_evt && !w_down_evt && (w_score < MAX_BIN)) begin
            if (r_ones == 4'd9) begin
              w_ones_next = 4'd0;
              w_tens_next = r_tens + 4'd1;
            end else begin
              w_ones_next = r_ones + 4'd1;
            end
            w_state_next = ST_LOCKED;
            w_lock_next  = '0;
            w_flash_next = FLASH_LOAD;
          end else if (w_down_evt && !w_up_evt && (w_score != 7'd0)) begin
            if (r_ones == 4'd0) begin
              w_ones_next = 4'd9;
              w_tens_next = r_tens - 4'd1;
            end else begin
              w_ones_next = r_ones - 4'd1;
            end
            w_state_next = ST_LOCKED;
            w_lock_next  = '0;
            w_flash_next = FLASH_LOAD;
          end
        end
        ST_LOCKED: begin
          // Leaving on the edge where the count reaches LOCKOUT_TIME-1 makes the
          // next edge (LOCKOUT_TIME after acceptance) the first one that can count.
          if (w_lock_inc >= LOCK_LAST) begin
            w_state_next = ST_READY;
            w_lock_next  = '0;
          end else begin
            w_lock_next = w_lock_inc;
          end
        end
        default: begin
          w_state_next = ST_READY;
          w_lock_next  = '0;
        end
      endcase
    end

    w_score_next = 7'(w_tens_next) * 7'd10 + 7'(w_ones_next);
  end

  assign bus.tens_o    = r_tens;
  assign bus.ones_o    = r_ones;
  assign bus.changed_o = (r_flash_cnt != 10'd0);
  assign bus.at_max_o  = r_at_max;
  assign bus.at_min_o  = r_at_min;

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - directed self-checking bench for score_counter
module tb_score_counter;

  logic clk_1khz;
  logic rst_n_i;
  int   n_cmp;
  int   n_fail;

  score_counter_if bus ();

  score_counter #(
    .MAX_SCORE    (99),
    .LOCKOUT_TIME (5),
    .FLASH_TIME   (250)
  ) dut (
    .clk_1khz (clk_1khz),
    .rst_n_i  (rst_n_i),
    .bus      (bus)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  task automatic pulse(input bit is_up, input int width, input int period);
    if (is_up) bus.count_up_i = 1'b1;
    else       bus.count_down_i = 1'b1;
    cycles(width);
    bus.count_up_i   = 1'b0;
    bus.count_down_i = 1'b0;
    cycles(period - width);
  endtask

  task automatic go_to(input int value);
    bus.clear_i = 1'b1;
    cycles(1);
    bus.clear_i = 1'b0;
    cycles(6);
    repeat (value) pulse(1'b1, 2, 8);
  endtask

  task automatic wait_flash_clear();
    int k;
    k = 0;
    while (bus.changed_o === 1'b1 && k < 400) begin
      cycles(1);
      k++;
    end
    n_cmp++;
    if (bus.changed_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flash_timeout: changed_o=%b after %0d cycles, required 0", bus.changed_o, k);
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst_n_i = 1'b0;
    bus.count_up_i   = 1'b1;
    bus.count_down_i = 1'b0;
    bus.clear_i      = 1'b0;
    cycles(2);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o, bus.at_max_o, bus.at_min_o} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: got %0d%0d ch=%b max=%b min=%b, required 00 ch=0 max=0 min=1",
               bus.tens_o, bus.ones_o, bus.changed_o, bus.at_max_o, bus.at_min_o);
    end
    rst_n_i = 1'b1;
    cycles(3);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o} !== {4'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL held_up_at_release: got %0d%0d ch=%b, required 00 ch=0", bus.tens_o, bus.ones_o, bus.changed_o);
    end
    bus.count_up_i = 1'b0;
    cycles(3);
    bus.count_up_i = 1'b1;
    cycles(1);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.at_min_o} !== {4'd0, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL first_pulse: got %0d%0d min=%b, required 01 min=0", bus.tens_o, bus.ones_o, bus.at_min_o);
    end
    cnt = 0;
    while (bus.changed_o === 1'b1 && cnt < 400) begin
      cnt++;
      if (cnt == 10) bus.count_up_i = 1'b0;
      cycles(1);
    end
    bus.count_up_i = 1'b0;
    n_cmp++;
    if (cnt != 250) begin
      n_fail++;
      $display("FAIL flash_length: changed_o high %0d cycles, required 250", cnt);
    end
    n_cmp++;
    if ({bus.tens_o, bus.ones_o} !== {4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL single_count_long_pulse: got %0d%0d, required 01", bus.tens_o, bus.ones_o);
    end
  endtask

  task automatic test_count_to_max();
    repeat (8) pulse(1'b1, 11, 20);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o} !== {4'd0, 4'd9}) begin
      n_fail++;
      $display("FAIL count_to_09: got %0d%0d, required 09", bus.tens_o, bus.ones_o);
    end
    pulse(1'b1, 11, 20);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o} !== {4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL carry_09_10: got %0d%0d, required 10", bus.tens_o, bus.ones_o);
    end
    repeat (9) pulse(1'b1, 11, 20);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o} !== {4'd1, 4'd9}) begin
      n_fail++;
      $display("FAIL count_to_19: got %0d%0d, required 19", bus.tens_o, bus.ones_o);
    end
    repeat (80) pulse(1'b1, 11, 20);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.at_max_o, bus.at_min_o} !== {4'd9, 4'd9, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL count_to_99: got %0d%0d max=%b min=%b, required 99 max=1 min=0",
               bus.tens_o, bus.ones_o, bus.at_max_o, bus.at_min_o);
    end
    wait_flash_clear();
    bus.count_up_i = 1'b1;
    cycles(1);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o, bus.at_max_o} !== {4'd9, 4'd9, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate_max: got %0d%0d ch=%b max=%b, required 99 ch=0 max=1",
               bus.tens_o, bus.ones_o, bus.changed_o, bus.at_max_o);
    end
    bus.count_up_i = 1'b0;
    cycles(10);
  endtask

  task automatic test_count_down_min();
    go_to(10);
    pulse(1'b0, 11, 20);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.at_max_o} !== {4'd0, 4'd9, 1'b0}) begin
      n_fail++;
      $display("FAIL borrow_10_09: got %0d%0d max=%b, required 09 max=0", bus.tens_o, bus.ones_o, bus.at_max_o);
    end
    go_to(0);
    cycles(10);
    bus.count_down_i = 1'b1;
    cycles(1);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.at_min_o} !== {4'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate_min: got %0d%0d min=%b, required 00 min=1", bus.tens_o, bus.ones_o, bus.at_min_o);
    end
    bus.count_down_i = 1'b0;
    bus.count_up_i   = 1'b1;
    cycles(1);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o} !== {4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL no_lockout_at_min: got %0d%0d, required 01", bus.tens_o, bus.ones_o);
    end
    bus.count_up_i = 1'b0;
    cycles(10);
  endtask

  task automatic test_lockout();
    bus.count_up_i = 1'b1;
    cycles(1);
    bus.count_up_i = 1'b0;
    n_cmp++;
    if ({bus.tens_o, bus.ones_o} !== {4'd0, 4'd2}) begin
      n_fail++;
      $display("FAIL lockout_first_up: got %0d%0d, required 02", bus.tens_o, bus.ones_o);
    end
    cycles(2);
    bus.count_down_i = 1'b1;
    cycles(1);
    bus.count_down_i = 1'b0;
    n_cmp++;
    if ({bus.tens_o, bus.ones_o} !== {4'd0, 4'd2}) begin
      n_fail++;
      $display("FAIL lockout_ignore_3: got %0d%0d, required 02", bus.tens_o, bus.ones_o);
    end
    cycles(1);
    bus.count_down_i = 1'b1;
    cycles(1);
    bus.count_down_i = 1'b0;
    n_cmp++;
    if ({bus.tens_o, bus.ones_o} !== {4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL lockout_accept_5: got %0d%0d, required 01", bus.tens_o, bus.ones_o);
    end
    cycles(10);
  endtask

  task automatic test_simultaneous();
    go_to(42);
    wait_flash_clear();
    bus.count_up_i   = 1'b1;
    bus.count_down_i = 1'b1;
    cycles(1);
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o} !== {4'd4, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL simultaneous: got %0d%0d ch=%b, required 42 ch=0", bus.tens_o, bus.ones_o, bus.changed_o);
    end
    bus.count_up_i   = 1'b0;
    bus.count_down_i = 1'b0;
    cycles(1);
    bus.count_up_i = 1'b1;
    cycles(1);
    bus.count_up_i = 1'b0;
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o} !== {4'd4, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL simultaneous_no_lock: got %0d%0d ch=%b, required 43 ch=1", bus.tens_o, bus.ones_o, bus.changed_o);
    end
    cycles(10);
  endtask

  task automatic test_clear();
    go_to(57);
    wait_flash_clear();
    bus.clear_i    = 1'b1;
    bus.count_up_i = 1'b1;
    cycles(1);
    bus.clear_i    = 1'b0;
    bus.count_up_i = 1'b0;
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o, bus.at_min_o} !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_57: got %0d%0d ch=%b min=%b, required 00 ch=1 min=1",
               bus.tens_o, bus.ones_o, bus.changed_o, bus.at_min_o);
    end
    wait_flash_clear();
    bus.clear_i = 1'b1;
    cycles(1);
    bus.clear_i = 1'b0;
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o} !== {4'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_at_00: got %0d%0d ch=%b, required 00 ch=0", bus.tens_o, bus.ones_o, bus.changed_o);
    end
    cycles(5);
  endtask

  task automatic test_reset_mid_lockout();
    bus.count_up_i = 1'b1;
    cycles(1);
    bus.count_up_i = 1'b0;
    cycles(1);
    #2;
    rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o, bus.at_max_o, bus.at_min_o} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got %0d%0d ch=%b max=%b min=%b, required 00 ch=0 max=0 min=1",
               bus.tens_o, bus.ones_o, bus.changed_o, bus.at_max_o, bus.at_min_o);
    end
    cycles(2);
    rst_n_i = 1'b1;
    cycles(2);
    bus.count_up_i = 1'b1;
    cycles(1);
    bus.count_up_i = 1'b0;
    n_cmp++;
    if ({bus.tens_o, bus.ones_o, bus.changed_o} !== {4'd0, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL after_reset_count: got %0d%0d ch=%b, required 01 ch=1", bus.tens_o, bus.ones_o, bus.changed_o);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_count_to_max();
    test_count_down_min();
    test_lockout();
    test_simultaneous();
    test_clear();
    test_reset_mid_lockout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
